// File: rtl/ex_mem_dmem_fwd_pkg.sv
// Shared encodings and instruction-decode helpers for the memory-stage slice.
package ex_mem_dmem_fwd_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [1:0] {
    ST_BYTE = 2'b00,
    ST_HALF = 2'b01,
    ST_WORD = 2'b10,
    ST_NONE = 2'b11
  } store_size_e;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } load_adj_e;

  typedef enum logic [1:0] {
    FWD_REG    = 2'b00,
    FWD_EX_MEM = 2'b01,
    FWD_MEM_WB = 2'b10,
    FWD_LAST   = 2'b11
  } fwd_sel_e;

  function automatic logic writes_rd(input logic [31:0] inst);
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [31:0] inst);
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP,
      OPC_STORE, OPC_BRANCH, OPC_JALR: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [31:0] inst);
    case (inst[6:0])
      OPC_OP, OPC_STORE, OPC_BRANCH: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // Producer writes a non-zero rd equal to the given source register.
  function automatic logic rd_hit(input logic [31:0] prod, input logic [4:0] src);
    return writes_rd(prod) && (prod[11:7] != 5'd0) && (prod[11:7] == src);
  endfunction

  // A load still in MEM has no data yet, so it is skipped for the EX/MEM path.
  function automatic fwd_sel_e select_fwd(input logic used, input logic [4:0] src,
                                          input logic [31:0] p1, input logic [31:0] p2,
                                          input logic [31:0] p3);
    if (!used)                                        return FWD_REG;
    if (rd_hit(p1, src) && (p1[6:0] != OPC_LOAD))     return FWD_EX_MEM;
    if (rd_hit(p2, src))                              return FWD_MEM_WB;
    if (rd_hit(p3, src))                              return FWD_LAST;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory, synchronous write, combinational read.
module data_mem
  import ex_mem_dmem_fwd_pkg::*;
#(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic [31:0] addr,
  input  logic [31:0] data_w,
  input  logic        mem_rw,
  input  logic [1:0]  store_size,
  input  logic [2:0]  load_adj,
  output logic [31:0] data_r
);

  localparam int unsigned NBYTES = 4 * DMEM_WORDS;
  localparam int unsigned AW     = $clog2(NBYTES);

  logic [7:0]    mem [NBYTES];
  logic [AW-1:0] ba  [4];
  logic [31:0]   word;

  // Each lane address wraps on its own, so misaligned accesses straddle the top.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      ba[k] = AW'(addr + 32'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (mem_rw) begin
      case (store_size)
        ST_BYTE: mem[ba[0]] <= data_w[7:0];
        ST_HALF: begin
          mem[ba[0]] <= data_w[7:0];
          mem[ba[1]] <= data_w[15:8];
        end
        ST_WORD: begin
          mem[ba[0]] <= data_w[7:0];
          mem[ba[1]] <= data_w[15:8];
          mem[ba[2]] <= data_w[23:16];
          mem[ba[3]] <= data_w[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    word = {mem[ba[3]], mem[ba[2]], mem[ba[1]], mem[ba[0]]};
    case (load_adj)
      LD_B:    data_r = {{24{word[7]}}, word[7:0]};
      LD_H:    data_r = {{16{word[15]}}, word[15:0]};
      LD_W:    data_r = word;
      LD_BU:   data_r = {24'd0, word[7:0]};
      LD_HU:   data_r = {16'd0, word[15:0]};
      default: data_r = word;
    endcase
  end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register; reset outranks the load enable.
module ex_mem_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_inst,
  input  logic        ex_MemRW,
  input  logic        ex_regWEn,
  input  logic [1:0]  ex_WBSel,
  input  logic [1:0]  ex_mem_ctrl_datain,
  input  logic [2:0]  ex_mem_ctrl_dataOutAddj,
  output logic [31:0] mem_alu,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_rs2,
  output logic [31:0] mem_inst,
  output logic        mem_MemRW,
  output logic        mem_regWEn,
  output logic [1:0]  mem_WBSel,
  output logic [1:0]  mem_ctrl_datain,
  output logic [2:0]  mem_ctrl_dataOutAddj
);

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_alu              <= '0;
      mem_pc               <= '0;
      mem_rs2              <= '0;
      mem_inst             <= '0;
      mem_MemRW            <= 1'b0;
      mem_regWEn           <= 1'b0;
      mem_WBSel            <= '0;
      mem_ctrl_datain      <= '0;
      mem_ctrl_dataOutAddj <= '0;
    end else if (enable) begin
      mem_alu              <= ex_alu;
      mem_pc               <= ex_pc;
      mem_rs2              <= ex_rs2;
      mem_inst             <= ex_inst;
      mem_MemRW            <= ex_MemRW;
      mem_regWEn           <= ex_regWEn;
      mem_WBSel            <= ex_WBSel;
      mem_ctrl_datain      <= ex_mem_ctrl_datain;
      mem_ctrl_dataOutAddj <= ex_mem_ctrl_dataOutAddj;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// Operand-forward selection and load-use stall control for the EX stage.
module forwarding_unit
  import ex_mem_dmem_fwd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_t,
  input  logic [31:0] inst_t_1,
  input  logic [31:0] inst_t_2,
  input  logic [31:0] data_WB,
  output logic [3:0]  enableFF,
  output logic [3:0]  resetFF,
  output logic        enablePC,
  output logic [1:0]  A_sel,
  output logic [1:0]  B_sel,
  output logic [31:0] data_last_load
);

  logic [31:0] inst_t_3;
  logic        load_use;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_t_3       <= '0;
      data_last_load <= '0;
    end else begin
      inst_t_3       <= inst_t_2;
      data_last_load <= data_WB;
    end
  end

  always_comb begin
    A_sel    = select_fwd(uses_rs1(inst_t), inst_t[19:15], inst_t_1, inst_t_2, inst_t_3);
    B_sel    = select_fwd(uses_rs2(inst_t), inst_t[24:20], inst_t_1, inst_t_2, inst_t_3);
    load_use = (inst_t_1[6:0] == OPC_LOAD) && (inst_t_1[11:7] != 5'd0) &&
               ((uses_rs1(inst_t) && (inst_t_1[11:7] == inst_t[19:15])) ||
                (uses_rs2(inst_t) && (inst_t_1[11:7] == inst_t[24:20])));
    // Hold PC, IF/ID, ID/EX; inject a bubble into EX/MEM for one cycle.
    enablePC = !load_use;
    enableFF = load_use ? 4'b0011 : 4'b1111;
    resetFF  = load_use ? 4'b0010 : 4'b0000;
  end

endmodule

// File: rtl/ex_mem_dmem_fwd.sv
// Memory-stage slice: EX/MEM register, data memory and forwarding/hazard unit.
module ex_mem_dmem_fwd #(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs2,
  input  logic [31:0] ex_inst,
  input  logic        ex_MemRW,
  input  logic        ex_regWEn,
  input  logic [1:0]  ex_WBSel,
  input  logic [1:0]  ex_mem_ctrl_datain,
  input  logic [2:0]  ex_mem_ctrl_dataOutAddj,
  output logic [31:0] mem_alu,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_rs2,
  output logic [31:0] mem_inst,
  output logic        mem_MemRW,
  output logic        mem_regWEn,
  output logic [1:0]  mem_WBSel,
  output logic [1:0]  mem_ctrl_datain,
  output logic [2:0]  mem_ctrl_dataOutAddj,
  output logic [31:0] DataR,
  input  logic [31:0] inst_t,
  input  logic [31:0] inst_t_1,
  input  logic [31:0] inst_t_2,
  input  logic [31:0] data_WB,
  output logic [3:0]  enableFF,
  output logic [3:0]  resetFF,
  output logic        enablePC,
  output logic [1:0]  A_sel,
  output logic [1:0]  B_sel,
  output logic [31:0] data_last_load
);

  ex_mem_reg u_ex_mem_reg (
    .clk                     (clk),
    .reset                   (reset),
    .enable                  (enable),
    .ex_alu                  (ex_alu),
    .ex_pc                   (ex_pc),
    .ex_rs2                  (ex_rs2),
    .ex_inst                 (ex_inst),
    .ex_MemRW                (ex_MemRW),
    .ex_regWEn               (ex_regWEn),
    .ex_WBSel                (ex_WBSel),
    .ex_mem_ctrl_datain      (ex_mem_ctrl_datain),
    .ex_mem_ctrl_dataOutAddj (ex_mem_ctrl_dataOutAddj),
    .mem_alu                 (mem_alu),
    .mem_pc                  (mem_pc),
    .mem_rs2                 (mem_rs2),
    .mem_inst                (mem_inst),
    .mem_MemRW               (mem_MemRW),
    .mem_regWEn              (mem_regWEn),
    .mem_WBSel               (mem_WBSel),
    .mem_ctrl_datain         (mem_ctrl_datain),
    .mem_ctrl_dataOutAddj    (mem_ctrl_dataOutAddj)
  );

  data_mem #(.DMEM_WORDS(DMEM_WORDS)) u_data_mem (
    .clk        (clk),
    .addr       (mem_alu),
    .data_w     (mem_rs2),
    .mem_rw     (mem_MemRW),
    .store_size (mem_ctrl_datain),
    .load_adj   (mem_ctrl_dataOutAddj),
    .data_r     (DataR)
  );

  forwarding_unit u_forwarding_unit (
    .clk            (clk),
    .reset          (reset),
    .inst_t         (inst_t),
    .inst_t_1       (inst_t_1),
    .inst_t_2       (inst_t_2),
    .data_WB        (data_WB),
    .enableFF       (enableFF),
    .resetFF        (resetFF),
    .enablePC       (enablePC),
    .A_sel          (A_sel),
    .B_sel          (B_sel),
    .data_last_load (data_last_load)
  );

endmodule

// File: tb/tb_ex_mem_dmem_fwd.sv
// Directed bench for the memory-stage slice with hand-computed expectations.
module tb_ex_mem_dmem_fwd;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] ex_alu, ex_pc, ex_rs2, ex_inst;
  logic        ex_MemRW, ex_regWEn;
  logic [1:0]  ex_WBSel, ex_mem_ctrl_datain;
  logic [2:0]  ex_mem_ctrl_dataOutAddj;
  logic [31:0] mem_alu, mem_pc, mem_rs2, mem_inst;
  logic        mem_MemRW, mem_regWEn;
  logic [1:0]  mem_WBSel, mem_ctrl_datain;
  logic [2:0]  mem_ctrl_dataOutAddj;
  logic [31:0] DataR;
  logic [31:0] inst_t, inst_t_1, inst_t_2, data_WB;
  logic [3:0]  enableFF, resetFF;
  logic        enablePC;
  logic [1:0]  A_sel, B_sel;
  logic [31:0] data_last_load;

  int n_cmp = 0;
  int n_err = 0;

  ex_mem_dmem_fwd #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .ex_alu(ex_alu), .ex_pc(ex_pc), .ex_rs2(ex_rs2), .ex_inst(ex_inst),
    .ex_MemRW(ex_MemRW), .ex_regWEn(ex_regWEn), .ex_WBSel(ex_WBSel),
    .ex_mem_ctrl_datain(ex_mem_ctrl_datain), .ex_mem_ctrl_dataOutAddj(ex_mem_ctrl_dataOutAddj),
    .mem_alu(mem_alu), .mem_pc(mem_pc), .mem_rs2(mem_rs2), .mem_inst(mem_inst),
    .mem_MemRW(mem_MemRW), .mem_regWEn(mem_regWEn), .mem_WBSel(mem_WBSel),
    .mem_ctrl_datain(mem_ctrl_datain), .mem_ctrl_dataOutAddj(mem_ctrl_dataOutAddj),
    .DataR(DataR), .inst_t(inst_t), .inst_t_1(inst_t_1), .inst_t_2(inst_t_2),
    .data_WB(data_WB), .enableFF(enableFF), .resetFF(resetFF), .enablePC(enablePC),
    .A_sel(A_sel), .B_sel(B_sel), .data_last_load(data_last_load)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, op};
  endfunction

  // Drive one EX-stage memory op into the EX/MEM register inputs.
  task automatic ex_op(input logic [31:0] a, input logic [31:0] d, input logic rw,
                       input logic [1:0] sz, input logic [2:0] adj);
    ex_alu = a; ex_rs2 = d; ex_MemRW = rw;
    ex_mem_ctrl_datain = sz; ex_mem_ctrl_dataOutAddj = adj;
  endtask

  logic [31:0] add_x5, sub_x6, nop, lw_x7, add_x8, addi_x8, addi_x0, rd_x0;

  initial begin
    add_x5  = enc_r(7'b0000000, 5'd5, 5'd1, 5'd2);
    sub_x6  = enc_r(7'b0100000, 5'd6, 5'd5, 5'd5);
    nop     = 32'h0000_0013;
    lw_x7   = enc_i(7'b0000011, 5'd7, 5'd1, 12'd0);
    add_x8  = enc_r(7'b0000000, 5'd8, 5'd7, 5'd1);
    addi_x8 = enc_i(7'b0010011, 5'd8, 5'd1, 12'd7);
    addi_x0 = enc_i(7'b0010011, 5'd0, 5'd0, 12'd1);
    rd_x0   = enc_r(7'b0000000, 5'd9, 5'd0, 5'd0);

    reset = 1'b1; enable = 1'b1;
    ex_alu = 32'hDEAD_0001; ex_pc = 32'h0000_0400; ex_rs2 = 32'h1; ex_inst = add_x5;
    ex_MemRW = 1'b0; ex_regWEn = 1'b1; ex_WBSel = 2'b01;
    ex_mem_ctrl_datain = 2'b11; ex_mem_ctrl_dataOutAddj = 3'b010;
    inst_t = '0; inst_t_1 = '0; inst_t_2 = 32'h1234_5678; data_WB = 32'h5555_AAAA;
    tick(); tick();

    // Reset beats enable and clears history
    check("rst_mem_alu",  mem_alu, 32'h0);
    check("rst_mem_inst", mem_inst, 32'h0);
    check("rst_regwen",   {31'd0, mem_regWEn}, 32'h0);
    check("rst_dll",      data_last_load, 32'h0);
    check("rst_enpc",     {31'd0, enablePC}, 32'h1);
    check("rst_enff",     {28'd0, enableFF}, 32'hF);

    // EX/MEM capture / hold / reset
    reset = 1'b0; inst_t_2 = '0; data_WB = '0;
    ex_alu = 32'h10; ex_pc = 32'h100; ex_inst = 32'h1234_5678; ex_WBSel = 2'b10;
    tick();
    check("cap_alu",   mem_alu, 32'h10);
    check("cap_pc",    mem_pc, 32'h100);
    check("cap_inst",  mem_inst, 32'h1234_5678);
    check("cap_wbsel", {30'd0, mem_WBSel}, 32'h2);
    enable = 1'b0; ex_alu = 32'h20;
    tick();
    check("hold_alu", mem_alu, 32'h10);
    enable = 1'b1; reset = 1'b1;
    tick();
    check("rst2_alu",   mem_alu, 32'h0);
    check("rst2_pc",    mem_pc, 32'h0);
    check("rst2_wbsel", {30'd0, mem_WBSel}, 32'h0);
    reset = 1'b0;

    // DMEM: SW 0x8899AABB @8, then loads
    ex_op(32'd8, 32'h8899_AABB, 1'b1, 2'b10, 3'b010); tick();
    ex_op(32'd9, 32'h0, 1'b0, 2'b11, 3'b000); tick();
    check("lb_9", DataR, 32'hFFFF_FFAA);
    ex_op(32'd10, 32'h0, 1'b0, 2'b11, 3'b101); tick();
    check("lhu_10", DataR, 32'h0000_8899);
    ex_op(32'd8, 32'h0, 1'b0, 2'b11, 3'b010); tick();
    check("lw_8", DataR, 32'h8899_AABB);
    ex_op(32'd11, 32'h0, 1'b0, 2'b11, 3'b100); tick();
    check("lbu_11", DataR, 32'h0000_0088);
    ex_op(32'd8, 32'h0, 1'b0, 2'b11, 3'b001); tick();
    check("lh_8", DataR, 32'hFFFF_AABB);
    // SB then size-11 store that must not write
    ex_op(32'd9, 32'h1234_5655, 1'b1, 2'b00, 3'b010); tick();
    ex_op(32'd8, 32'hDEAD_BEEF, 1'b1, 2'b11, 3'b010); tick();
    ex_op(32'd8, 32'h0, 1'b0, 2'b11, 3'b010); tick();
    check("lw_after_sb", DataR, 32'h8899_55BB);
    ex_op(32'd4104, 32'h0, 1'b0, 2'b11, 3'b011); tick();
    check("lw_wrap", DataR, 32'h8899_55BB);
    // SH straddling the top of memory wraps to address 0
    ex_op(32'd4095, 32'h0000_C3D4, 1'b1, 2'b01, 3'b010); tick();
    ex_op(32'd0, 32'h0, 1'b0, 2'b11, 3'b100); tick();
    check("sh_wrap_lo", DataR, 32'h0000_00C3);
    ex_op(32'd4095, 32'h0, 1'b0, 2'b11, 3'b001); tick();
    check("lh_wrap", DataR, 32'hFFFF_C3D4);

    // Back-to-back ALU forward
    inst_t = sub_x6; inst_t_1 = add_x5; inst_t_2 = nop; #1;
    check("d1_a",    {30'd0, A_sel}, 32'h1);
    check("d1_b",    {30'd0, B_sel}, 32'h1);
    check("d1_enpc", {31'd0, enablePC}, 32'h1);
    check("d1_rff",  {28'd0, resetFF}, 32'h0);
    // EX/MEM wins over MEM/WB
    inst_t_2 = add_x5; #1;
    check("prio_a", {30'd0, A_sel}, 32'h1);
    // Distance 2
    inst_t_1 = nop; data_WB = 32'hCAFE_0001; #1;
    check("d2_a", {30'd0, A_sel}, 32'h2);
    check("d2_b", {30'd0, B_sel}, 32'h2);
    tick();
    // Distance 3
    inst_t_2 = nop; data_WB = 32'h0BAD_0000; #1;
    check("d3_a",   {30'd0, A_sel}, 32'h3);
    check("d3_b",   {30'd0, B_sel}, 32'h3);
    check("d3_dll", data_last_load, 32'hCAFE_0001);
    tick();
    check("d4_a", {30'd0, A_sel}, 32'h0);

    // Load-use stall
    inst_t = add_x8; inst_t_1 = lw_x7; inst_t_2 = nop; #1;
    check("lu_enpc", {31'd0, enablePC}, 32'h0);
    check("lu_enff", {28'd0, enableFF}, 32'h3);
    check("lu_rff",  {28'd0, resetFF}, 32'h2);
    check("lu_a",    {30'd0, A_sel}, 32'h0);
    tick();
    inst_t_1 = '0; inst_t_2 = lw_x7; #1;
    check("lu_next_a",    {30'd0, A_sel}, 32'h2);
    check("lu_next_enpc", {31'd0, enablePC}, 32'h1);
    check("lu_next_enff", {28'd0, enableFF}, 32'hF);
    // I-type imm bits alias rd of the load in the rs2 field: no stall
    inst_t = addi_x8; inst_t_1 = enc_i(7'b0000011, 5'd7, 5'd3, 12'd0); inst_t_2 = nop; #1;
    check("imm_nostall", {31'd0, enablePC}, 32'h1);
    check("imm_b",       {30'd0, B_sel}, 32'h0);

    // x0 destination never forwards
    inst_t = rd_x0; inst_t_1 = addi_x0; inst_t_2 = addi_x0; #1;
    check("x0_a", {30'd0, A_sel}, 32'h0);
    check("x0_b", {30'd0, B_sel}, 32'h0);

    // Reset mid-operation wipes the distance-3 history
    tick();
    inst_t_2 = add_x5; data_WB = 32'h1234_0000; reset = 1'b1;
    tick();
    reset = 1'b0; inst_t = sub_x6; inst_t_1 = nop; inst_t_2 = nop; #1;
    check("rst_hist_a",   {30'd0, A_sel}, 32'h0);
    check("rst_hist_dll", data_last_load, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
